lzs_copy_sched: RTL and testbench

Sequencer for the LZS decode history datapath. It takes parsed literal and copy commands from the bitstream parser and drives one synchronous-read port and one write port of the 2048 x 8 history RAM. Each copy becomes a stream of per-byte reads; every produced byte is written back into history and queued to the output stream. It handles overlapping copies (offset 1 / offset 2) and output back-pressure, and keeps the history write pointer.

---
 rtl/lzs_copy_sched.sv | 150 +++++++++++++++
 tb/tb_lzs_copy_sched.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lzs_copy_sched.sv
// LZS decode history sequencer: turns literal/copy commands into history RAM
// reads and writes, buffers produced bytes in a 2-entry output FIFO.
module lzs_copy_sched #(
    parameter int unsigned LENGTH_WIDTH = 16,
    parameter int unsigned OFFSET_WIDTH = 12,
    parameter int unsigned ADDR_WIDTH   = 11
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_is_copy,
    input  logic [7:0]              cmd_literal,
    input  logic [OFFSET_WIDTH-1:0] cmd_offset,
    input  logic [LENGTH_WIDTH-1:0] cmd_length,
    output logic                    hist_ren,
    output logic [ADDR_WIDTH-1:0]   hist_raddr,
    input  logic [7:0]              hist_rdata,
    output logic                    hist_wen,
    output logic [ADDR_WIDTH-1:0]   hist_waddr,
    output logic [7:0]              hist_wdata,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    busy,
    output logic                    err_offset
);

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_COPY = 1'b1} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ip_q, raddr_q, prod_addr_q;
    logic [LENGTH_WIDTH-1:0] rem_q;
    logic                    prod_valid_q, prod_is_lit_q, fwd_q, err_q;
    logic [7:0]              prod_lit_q, fwd_data_q;
    logic [7:0]              fifo_q [2];
    logic                    head_q;
    logic [1:0]              cnt_q;

    logic       credit, accept, off_ok, start_copy, issue, pop, pop_fifo, push;
    logic [1:0] occ;
    logic [7:0] prod_byte;
    logic       widx;

    // Bytes owed to the output: buffered plus the one being produced this cycle.
    assign occ        = cnt_q + 2'(prod_valid_q);
    assign credit     = occ < 2'd2;
    assign accept     = cmd_valid && cmd_ready;
    assign off_ok     = (cmd_offset != '0) && ((cmd_offset >> ADDR_WIDTH) == '0);
    assign start_copy = accept && cmd_is_copy && off_ok && (cmd_length != '0);
    assign issue      = (state_q == S_COPY) && credit;

    // Offset-1 reads hit the address written in the same cycle; use the captured write byte.
    assign prod_byte  = prod_is_lit_q ? prod_lit_q : (fwd_q ? fwd_data_q : hist_rdata);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_copy) state_d = S_COPY;
            S_COPY:  if (issue && (rem_q == LENGTH_WIDTH'(1))) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        hist_ren  = 1'b0;
        busy      = out_valid;
        case (state_q)
            S_IDLE: cmd_ready = credit;
            S_COPY: begin
                hist_ren = credit;
                busy     = 1'b1;
            end
            default: ;
        endcase
    end

    assign hist_raddr = raddr_q;
    assign hist_wen   = prod_valid_q;
    assign hist_waddr = prod_addr_q;
    assign hist_wdata = prod_valid_q ? prod_byte : 8'h00;
    assign err_offset = err_q;

    // Empty FIFO passes the produced byte straight through to the output.
    assign out_valid = (cnt_q != 2'd0) || prod_valid_q;
    assign out_data  = (cnt_q != 2'd0) ? fifo_q[head_q] : hist_wdata;
    assign pop       = out_valid && out_ready;
    assign pop_fifo  = pop && (cnt_q != 2'd0);
    assign push      = prod_valid_q && !(pop && (cnt_q == 2'd0));
    assign widx      = head_q ^ cnt_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ip_q          <= '0;
            raddr_q       <= '0;
            rem_q         <= '0;
            prod_valid_q  <= 1'b0;
            prod_is_lit_q <= 1'b0;
            prod_lit_q    <= 8'h00;
            prod_addr_q   <= '0;
            fwd_q         <= 1'b0;
            fwd_data_q    <= 8'h00;
            err_q         <= 1'b0;
        end else begin
            err_q        <= accept && cmd_is_copy && !off_ok;
            prod_valid_q <= 1'b0;
            if (accept && !cmd_is_copy) begin
                prod_valid_q  <= 1'b1;
                prod_is_lit_q <= 1'b1;
                prod_lit_q    <= cmd_literal;
                prod_addr_q   <= ip_q;
                ip_q          <= ip_q + ADDR_WIDTH'(1);
            end else if (issue) begin
                prod_valid_q  <= 1'b1;
                prod_is_lit_q <= 1'b0;
                prod_addr_q   <= ip_q;
                fwd_q         <= hist_wen && (raddr_q == prod_addr_q);
                fwd_data_q    <= hist_wdata;
                ip_q          <= ip_q + ADDR_WIDTH'(1);
                raddr_q       <= raddr_q + ADDR_WIDTH'(1);
                rem_q         <= rem_q - LENGTH_WIDTH'(1);
            end
            if (start_copy) begin
                raddr_q <= ip_q - ADDR_WIDTH'(cmd_offset);
                rem_q   <= cmd_length;
            end
        end
    end

    // Output FIFO; credit guarantees a push never meets a full buffer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_q[0] <= 8'h00;
            fifo_q[1] <= 8'h00;
            head_q    <= 1'b0;
            cnt_q     <= 2'd0;
        end else begin
            if (push) fifo_q[widx] <= prod_byte;
            if (pop_fifo) head_q <= ~head_q;
            cnt_q <= cnt_q + 2'(push) - 2'(pop_fifo);
        end
    end

endmodule

// File: tb/tb_lzs_copy_sched.sv
// Scoreboard bench for lzs_copy_sched with a synchronous-read history RAM model.
module tb_lzs_copy_sched;
    localparam int unsigned LW = 16;
    localparam int unsigned OW = 12;
    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_is_copy;
    logic [7:0]    cmd_literal;
    logic [OW-1:0] cmd_offset;
    logic [LW-1:0] cmd_length;
    logic          hist_ren, hist_wen;
    logic [AW-1:0] hist_raddr, hist_waddr;
    logic [7:0]    hist_rdata, hist_wdata, out_data;
    logic          out_valid, out_ready, busy, err_offset;

    logic          ready_level, toggle_en;
    logic [3:0]    pat = 4'b1001;
    logic [7:0]    ram [2048];

    int            n_tests = 0, n_fail = 0, owed = 0;
    logic [7:0]    oq [$];
    logic [AW+7:0] wq [$];
    logic [AW-1:0] rq [$];
    logic [AW-1:0] tb_ip = '0;

    always #5 clk = ~clk;

    lzs_copy_sched #(.LENGTH_WIDTH(LW), .OFFSET_WIDTH(OW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_is_copy(cmd_is_copy), .cmd_literal(cmd_literal), .cmd_offset(cmd_offset),
        .cmd_length(cmd_length), .hist_ren(hist_ren), .hist_raddr(hist_raddr),
        .hist_rdata(hist_rdata), .hist_wen(hist_wen), .hist_waddr(hist_waddr),
        .hist_wdata(hist_wdata), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .busy(busy), .err_offset(err_offset)
    );

    // History RAM: synchronous read returning old data on a same-address write.
    initial begin
        hist_rdata = 8'h00;
        for (int i = 0; i < 2048; i++) ram[i] = 8'(i);
        forever begin
            @(posedge clk);
            if (hist_ren) hist_rdata <= ram[hist_raddr];
            if (hist_wen) ram[hist_waddr] <= hist_wdata;
        end
    end

    initial begin
        out_ready = 1'b1;
        for (int ph = 0; ; ph++) begin
            @(posedge clk); #1;
            out_ready = toggle_en ? pat[ph % 4] : ready_level;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: event seen, none expected", name);
    endtask

    // Monitor: pops expected writes/reads/output bytes as the DUT presents them.
    initial begin
        logic [AW+7:0] ew;
        forever begin
            @(negedge clk);
            if (rst) owed = 0;
            else begin
                if (hist_wen) begin
                    if (wq.size() == 0) unexpected("hist_wen");
                    else begin ew = wq.pop_front(); chk("hist_write", 32'({hist_waddr, hist_wdata}), 32'(ew)); end
                end
                if (hist_ren) begin
                    chk("credit_at_read", 32'(owed < 2), 32'(1));
                    if (rq.size() == 0) unexpected("hist_ren");
                    else chk("hist_raddr", 32'(hist_raddr), 32'(rq.pop_front()));
                end
                if (out_valid && out_ready) begin
                    if (oq.size() == 0) unexpected("out_valid");
                    else chk("out_data", 32'(out_data), 32'(oq.pop_front()));
                end
                owed += int'(hist_ren) + int'(cmd_valid && cmd_ready && !cmd_is_copy)
                        - int'(out_valid && out_ready);
            end
        end
    end

    task automatic send(input logic is_copy, input logic [7:0] lit,
                        input logic [OW-1:0] off, input logic [LW-1:0] len);
        int k = 0;
        cmd_valid = 1'b1; cmd_is_copy = is_copy; cmd_literal = lit;
        cmd_offset = off; cmd_length = len;
        @(negedge clk);
        while (!cmd_ready && k < 100) begin @(negedge clk); k++; end
        if (!cmd_ready) chk("cmd_ready_timeout", 32'(cmd_ready), 32'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic lit(input logic [7:0] d);
        wq.push_back({tb_ip, d});
        oq.push_back(d);
        tb_ip = tb_ip + AW'(1);
        send(1'b0, d, '0, '0);
    endtask

    task automatic exp_copy_byte(input logic [AW-1:0] ra, input logic [7:0] d);
        rq.push_back(ra);
        wq.push_back({tb_ip, d});
        oq.push_back(d);
        tb_ip = tb_ip + AW'(1);
    endtask

    task automatic drain();
        int k = 0;
        while ((oq.size() + wq.size() + rq.size()) != 0 && k < 300) begin @(posedge clk); #1; k++; end
        chk("drain_left", 32'(oq.size() + wq.size() + rq.size()), 32'(0));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'(1));
        chk({tag, "_hist_ren"}, 32'(hist_ren), 32'(0));
        chk({tag, "_hist_wen"}, 32'(hist_wen), 32'(0));
        chk({tag, "_hist_raddr"}, 32'(hist_raddr), 32'(0));
        chk({tag, "_hist_waddr"}, 32'(hist_waddr), 32'(0));
        chk({tag, "_hist_wdata"}, 32'(hist_wdata), 32'(0));
        chk({tag, "_out_valid"}, 32'(out_valid), 32'(0));
        chk({tag, "_out_data"}, 32'(out_data), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
        chk({tag, "_err_offset"}, 32'(err_offset), 32'(0));
    endtask

    initial begin
        logic [7:0] t3 [8];
        t3 = '{8'h10, 8'h20, 8'h30, 8'h10, 8'h20, 8'h30, 8'h10, 8'h20};
        rst = 1'b1; cmd_valid = 1'b0; cmd_is_copy = 1'b0; cmd_literal = 8'h00;
        cmd_offset = '0; cmd_length = '0; ready_level = 1'b1; toggle_en = 1'b0;
        repeat (3) @(posedge clk); #1;
        chk_reset_vals("reset");
        rst = 1'b0;
        @(posedge clk); #1;

        // A B then copy(2,5): A B A B A B A at addresses 0..6
        lit(8'h41); lit(8'h42);
        for (int i = 0; i < 5; i++) exp_copy_byte(AW'(i), (i % 2 == 0) ? 8'h41 : 8'h42);
        send(1'b1, 8'h00, OW'(2), LW'(5));
        drain();

        // 0x5A then overlapping copy(1,4)
        lit(8'h5A);
        for (int i = 0; i < 4; i++) exp_copy_byte(AW'(7 + i), 8'h5A);
        send(1'b1, 8'h00, OW'(1), LW'(4));
        @(negedge clk);
        chk("copy_first_ren", 32'(hist_ren), 32'(1));
        chk("copy_busy", 32'(busy), 32'(1));
        @(negedge clk);
        chk("copy_first_wen", 32'(hist_wen), 32'(1));
        chk("copy_first_valid", 32'(out_valid), 32'(1));
        drain();
        @(negedge clk);
        chk("busy_after_pop", 32'(busy), 32'(0));
        @(posedge clk); #1;

        // Back-pressure: copy(3,8) with out_ready pattern 1,0,0,1
        lit(8'h10); lit(8'h20); lit(8'h30);
        for (int i = 0; i < 8; i++) exp_copy_byte(AW'(12 + i), t3[i]);
        toggle_en = 1'b1;
        send(1'b1, 8'h00, OW'(3), LW'(8));
        drain();
        toggle_en = 1'b0;
        @(posedge clk); #1;

        // Wrap: fill to ip 2046, then copy(4,6)
        while (tb_ip != AW'(2046)) lit(8'(tb_ip));
        exp_copy_byte(AW'(2042), 8'hFA);
        exp_copy_byte(AW'(2043), 8'hFB);
        exp_copy_byte(AW'(2044), 8'hFC);
        exp_copy_byte(AW'(2045), 8'hFD);
        exp_copy_byte(AW'(2046), 8'hFA);
        exp_copy_byte(AW'(2047), 8'hFB);
        send(1'b1, 8'h00, OW'(4), LW'(6));
        drain();
        chk("ip_wrapped", 32'(tb_ip), 32'(4));

        // Illegal offsets and zero length
        send(1'b1, 8'h00, OW'(0), LW'(3));
        @(negedge clk); chk("err_off0", 32'(err_offset), 32'(1));
        @(negedge clk); chk("err_off0_pulse", 32'(err_offset), 32'(0));
        @(posedge clk); #1;
        send(1'b1, 8'h00, OW'(2048), LW'(3));
        @(negedge clk); chk("err_off2048", 32'(err_offset), 32'(1));
        @(negedge clk); chk("err_off2048_pulse", 32'(err_offset), 32'(0));
        @(posedge clk); #1;
        send(1'b1, 8'h00, OW'(5), LW'(0));
        @(negedge clk); chk("len0_no_err", 32'(err_offset), 32'(0));
        chk("len0_idle", 32'(busy), 32'(0));
        repeat (3) @(negedge clk);
        @(posedge clk); #1;

        // Reset in the middle of copy(1,100)
        lit(8'h77);
        for (int i = 0; i < 100; i++) exp_copy_byte(AW'(4 + i), 8'h77);
        send(1'b1, 8'h00, OW'(1), LW'(100));
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_vals("midrst");
        oq.delete(); wq.delete(); rq.delete();
        tb_ip = '0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        lit(8'h11);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
